fir_stream_mac: RTL and testbench

- Parametrised, streaming, fixed-point direct-form FIR: y[n] = sum over k=0..TAPS-1 of b[k]*x[n-k].
- Time-multiplexes one multiplier and one accumulator across all taps.
- Keeps the sample history in an internal circular buffer and the coefficients in a runtime-writable register file.
- Sits between a sample source and a sink on valid/ready streams; replaces ROM-driven, one-shot filtering in the signal chain.

---
 rtl/fir_stream_mac.sv | 175 +++++++++++++++++
 tb/tb_fir_stream_mac.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_stream_mac.sv
// Streaming direct-form FIR: one shared multiplier/accumulator. FIR_ROUND_SAT_EN enables round-half-up and saturation on output.
// Latency TAPS+1 edges from acceptance to out_valid; in_ready only in IDLE, result held in OUT until out_ready.
module fir_stream_mac #(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int TAPS      = 51,
    parameter int ACC_W     = 40,
    parameter int OUT_SHIFT = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      coef_we,
    input  logic [$clog2(TAPS)-1:0]   coef_addr,
    input  logic [COEF_W-1:0]         coef_data,
    input  logic                      hist_clr,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic                      busy
);
    localparam int AW = $clog2(TAPS);
    localparam int PW = DATA_W + COEF_W;
    localparam logic [AW-1:0] LAST = AW'(TAPS - 1);

    localparam logic [2:0] S_CLEAR = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_MAC   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_OUT   = 3'd4;

    logic [2:0]               state_q, state_d;
    logic [AW-1:0]            clr_q, clr_d;
    logic [AW-1:0]            wptr_q, wptr_d;
    logic [AW-1:0]            rptr_q, rptr_d;
    logic [AW-1:0]            k_q, k_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [PW-1:0]     prod_q, prod_d;
    logic                     out_vld_q, out_vld_d;
    logic [DATA_W-1:0]        out_dat_q, out_dat_d;

    logic [DATA_W-1:0]        hist_q [TAPS];
    logic [COEF_W-1:0]        coef_q [TAPS];

    logic [COEF_W-1:0]        rd_coef;
    logic [DATA_W-1:0]        rd_hist;
    logic signed [PW-1:0]     coef_ext, hist_ext, product;
    logic signed [ACC_W-1:0]  acc_sum;
    logic [DATA_W-1:0]        y_red;
    logic                     accept;

    assign in_ready  = (state_q == S_IDLE) && !hist_clr;
    assign accept    = in_valid && in_ready;
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_vld_q;
    assign out_data  = out_dat_q;

    assign rd_coef  = coef_q[k_q];
    assign rd_hist  = hist_q[rptr_q];
    assign coef_ext = {{(PW-COEF_W){rd_coef[COEF_W-1]}}, rd_coef};
    assign hist_ext = {{(PW-DATA_W){rd_hist[DATA_W-1]}}, rd_hist};
    assign product  = coef_ext * hist_ext;
    // The product register lags by one cycle, so acc always folds in the previous tap.
    assign acc_sum  = acc_q + {{(ACC_W-PW){prod_q[PW-1]}}, prod_q};

`ifdef FIR_ROUND_SAT_EN
    localparam logic signed [ACC_W-1:0] RND  = ACC_W'((ACC_W'(1) << OUT_SHIFT) >> 1);
    localparam logic signed [ACC_W-1:0] SMAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SMIN = ~SMAX;
    logic signed [ACC_W-1:0] rnd_shift;

    always_comb begin
        rnd_shift = (acc_sum + RND) >>> OUT_SHIFT;
        if (rnd_shift > SMAX)      y_red = SMAX[DATA_W-1:0];
        else if (rnd_shift < SMIN) y_red = SMIN[DATA_W-1:0];
        else                       y_red = rnd_shift[DATA_W-1:0];
    end
`else
    always_comb y_red = DATA_W'(acc_sum >>> OUT_SHIFT);
`endif

    always_comb begin
        state_d   = state_q;
        clr_d     = clr_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        k_d       = k_q;
        acc_d     = acc_q;
        prod_d    = prod_q;
        out_vld_d = out_vld_q;
        out_dat_d = out_dat_q;
        case (state_q)
            S_CLEAR: begin
                clr_d = clr_q + AW'(1);
                if (clr_q == LAST) begin
                    clr_d   = '0;
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (hist_clr) begin
                    clr_d   = '0;
                    state_d = S_CLEAR;
                end else if (in_valid) begin
                    acc_d   = '0;
                    prod_d  = '0;
                    k_d     = '0;
                    rptr_d  = wptr_q;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                prod_d = product;
                acc_d  = acc_sum;
                k_d    = k_q + AW'(1);
                rptr_d = (rptr_q == '0) ? LAST : rptr_q - AW'(1);
                if (k_q == LAST) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                acc_d     = acc_sum;
                out_dat_d = y_red;
                out_vld_d = 1'b1;
                state_d   = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    out_vld_d = 1'b0;
                    wptr_d    = (wptr_q == LAST) ? '0 : wptr_q + AW'(1);
                    state_d   = S_IDLE;
                end
            end
            default: begin
                clr_d   = '0;
                state_d = S_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_CLEAR;
            clr_q     <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            k_q       <= '0;
            acc_q     <= '0;
            prod_q    <= '0;
            out_vld_q <= 1'b0;
            out_dat_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_q     <= clr_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            k_q       <= k_d;
            acc_q     <= acc_d;
            prod_q    <= prod_d;
            out_vld_q <= out_vld_d;
            out_dat_q <= out_dat_d;
        end
    end

    // Storage arrays carry no reset: history is zeroed by CLEAR, coefficients by software.
    always_ff @(posedge clk) begin
        if (state_q == S_CLEAR)
            hist_q[clr_q] <= '0;
        else if (accept)
            hist_q[wptr_q] <= in_data;
        if (coef_we && (state_q == S_IDLE || state_q == S_CLEAR)
            && ({1'b0, coef_addr} < (AW+1)'(TAPS)))
            coef_q[coef_addr] <= coef_data;
    end
endmodule

// File: tb/tb_fir_stream_mac.sv
module tb_fir_stream_mac;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic coef_we = 1'b0, hist_clr = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [1:0] coef_addr = '0;
    logic [15:0] coef_data = '0, in_data = '0;
    logic in_ready, out_valid, busy;
    logic signed [15:0] out_data;

    logic coef_we2 = 1'b0, in_valid2 = 1'b0, out_ready2 = 1'b0;
    logic [1:0] coef_addr2 = '0;
    logic [15:0] coef_data2 = '0, in_data2 = '0;
    logic in_ready2, out_valid2, busy2;
    logic signed [15:0] out_data2;

    int passed = 0;
    int total = 0;

    fir_stream_mac #(.DATA_W(16), .COEF_W(16), .TAPS(4), .ACC_W(40), .OUT_SHIFT(0)) dut (
        .clk(clk), .rst(rst), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .hist_clr(hist_clr), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy));

    fir_stream_mac #(.DATA_W(16), .COEF_W(16), .TAPS(4), .ACC_W(40), .OUT_SHIFT(15)) dut2 (
        .clk(clk), .rst(rst), .coef_we(coef_we2), .coef_addr(coef_addr2), .coef_data(coef_data2),
        .hist_clr(1'b0), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2), .busy(busy2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic load_coef(input int a, input int v);
        coef_we = 1'b1;
        coef_addr = 2'(a);
        coef_data = 16'(v);
        tick();
        coef_we = 1'b0;
    endtask

    task automatic pulse_clear();
        int n;
        hist_clr = 1'b1;
        tick();
        hist_clr = 1'b0;
        wait_ready(n);
    endtask

    task automatic run_sample(input int x, output logic signed [15:0] y, output int lat);
        int n;
        wait_ready(n);
        in_valid = 1'b1;
        in_data = 16'(x);
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        y = out_data;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        tick(); tick();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1 || out_data !== 16'sd0) begin
            $display("FAIL reset_vals got ov=%b ir=%b busy=%b od=%0d want 0 0 1 0", out_valid, in_ready, busy, out_data);
        end else passed++;
        rst = 1'b0;
        wait_ready(n);
        total++;
        if (n !== 4) $display("FAIL reset_clear_len got %0d want 4", n);
        else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL idle_busy got %b want 0", busy);
        else passed++;
    endtask

    task automatic test_impulse();
        int xs [5] = '{1, 0, 0, 0, 0};
        int ex [5] = '{1, 2, 3, 4, 0};
        logic signed [15:0] y;
        int lat;
        for (int i = 0; i < 4; i++) load_coef(i, i + 1);
        for (int i = 0; i < 5; i++) begin
            run_sample(xs[i], y, lat);
            total++;
            if (y !== 16'(ex[i])) $display("FAIL impulse[%0d] got %0d want %0d", i, y, ex[i]);
            else passed++;
            total++;
            if (lat !== 5) $display("FAIL impulse_lat[%0d] got %0d want 5", i, lat);
            else passed++;
        end
    endtask

    task automatic test_step();
        int ex [6] = '{1, 3, 6, 10, 10, 10};
        logic signed [15:0] y;
        int lat;
        for (int i = 0; i < 6; i++) begin
            run_sample(1, y, lat);
            total++;
            if (y !== 16'(ex[i])) $display("FAIL step[%0d] got %0d want %0d", i, y, ex[i]);
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        logic signed [15:0] y;
        int lat;
        pulse_clear();
        in_valid = 1'b1;
        in_data = 16'd1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        for (int c = 0; c < 6; c++) begin
            total++;
            if (out_data !== 16'sd1 || in_ready !== 1'b0 || out_valid !== 1'b1)
                $display("FAIL bp_hold[%0d] got od=%0d ir=%b ov=%b want 1 0 1", c, out_data, in_ready, out_valid);
            else passed++;
            if (c == 2) begin
                coef_we = 1'b1; coef_addr = 2'd0; coef_data = 16'd9;
            end
            tick();
            coef_we = 1'b0;
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        pulse_clear();
        run_sample(1, y, lat);
        total++;
        if (y !== 16'sd1) $display("FAIL coef_lock got %0d want 1", y);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int acc_c [8];
        int outs [8];
        int na = 0;
        int no = 0;
        int n = 0;
        pulse_clear();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 16'd1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (in_ready && na < 8) begin acc_c[na] = cyc; na++; end
            if (out_valid && no < 8) begin outs[no] = int'(out_data); no++; end
            tick();
        end
        in_valid = 1'b0;
        while (busy && n < 50) begin tick(); n++; end
        out_ready = 1'b0;
        total++;
        if (na < 4) $display("FAIL b2b_count got %0d want >=4", na);
        else passed++;
        for (int i = 1; i < 4 && i < na; i++) begin
            total++;
            if (acc_c[i] - acc_c[i-1] !== 7) $display("FAIL b2b_period[%0d] got %0d want 7", i, acc_c[i] - acc_c[i-1]);
            else passed++;
        end
        total++;
        if (no < 3 || outs[0] !== 1 || outs[1] !== 3 || outs[2] !== 6)
            $display("FAIL b2b_data got n=%0d %0d %0d %0d want 1 3 6", no, outs[0], outs[1], outs[2]);
        else passed++;
    endtask

    task automatic test_reset_abort();
        int ex [4] = '{1, 2, 3, 4};
        logic signed [15:0] y;
        int lat;
        int n = 0;
        logic seen = 1'b0;
        pulse_clear();
        in_valid = 1'b1;
        in_data = 16'd1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1)
            $display("FAIL abort_rst got ov=%b ir=%b busy=%b want 0 0 1", out_valid, in_ready, busy);
        else passed++;
        tick();
        rst = 1'b0;
        while (!in_ready && n < 50) begin
            if (out_valid) seen = 1'b1;
            tick();
            n++;
        end
        total++;
        if (n !== 4 || seen !== 1'b0) $display("FAIL abort_clear got len=%0d ov_seen=%b want 4 0", n, seen);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            run_sample(i == 0 ? 1 : 0, y, lat);
            total++;
            if (y !== 16'(ex[i])) $display("FAIL abort_impulse[%0d] got %0d want %0d", i, y, ex[i]);
            else passed++;
        end
    endtask

    task automatic test_hist_clr();
        logic signed [15:0] y0, y1, y2;
        int lat;
        int n;
        run_sample(5, y0, lat);
        run_sample(5, y1, lat);
        total++;
        if (y0 !== 16'sd5 || y1 !== 16'sd15) $display("FAIL pre_clr got %0d %0d want 5 15", y0, y1);
        else passed++;
        hist_clr = 1'b1;
        in_valid = 1'b1;
        in_data = 16'd7;
        #1;
        total++;
        if (in_ready !== 1'b0) $display("FAIL clr_wins got in_ready=%b want 0", in_ready);
        else passed++;
        tick();
        hist_clr = 1'b0;
        in_valid = 1'b0;
        wait_ready(n);
        total++;
        if (n !== 4) $display("FAIL clr_len got %0d want 4", n);
        else passed++;
        run_sample(1, y2, lat);
        total++;
        if (y2 !== 16'sd1) $display("FAIL post_clr got %0d want 1", y2);
        else passed++;
    endtask

    task automatic test_saturation();
        logic signed [15:0] y [4];
        logic [15:0] e0, e3;
        int lat;
`ifdef FIR_ROUND_SAT_EN
        e0 = 16'h7FFF; e3 = 16'h7FFF;
`else
        e0 = 16'h0001; e3 = 16'h0004;
`endif
        for (int i = 0; i < 4; i++) load_coef(i, 32767);
        pulse_clear();
        for (int i = 0; i < 4; i++) run_sample(32767, y[i], lat);
        total++;
        if (y[0] !== e0) $display("FAIL sat_first got %h want %h", y[0], e0);
        else passed++;
        total++;
        if (y[3] !== e3) $display("FAIL sat_fourth got %h want %h", y[3], e3);
        else passed++;
    endtask

    task automatic test_rounding();
        logic [15:0] e;
        int lat = 0;
`ifdef FIR_ROUND_SAT_EN
        e = 16'd2;
`else
        e = 16'd1;
`endif
        for (int i = 0; i < 4; i++) begin
            coef_we2 = 1'b1;
            coef_addr2 = 2'(i);
            coef_data2 = (i == 0) ? 16'd16384 : 16'd0;
            tick();
        end
        coef_we2 = 1'b0;
        in_valid2 = 1'b1;
        in_data2 = 16'd3;
        tick();
        in_valid2 = 1'b0;
        while (!out_valid2 && lat < 50) begin
            tick();
            lat++;
        end
        total++;
        if (out_data2 !== e || lat !== 5) $display("FAIL round got %0d lat %0d want %0d lat 5", out_data2, lat, e);
        else passed++;
        out_ready2 = 1'b1;
        tick();
        out_ready2 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_impulse();
        test_step();
        test_backpressure();
        test_back_to_back();
        test_reset_abort();
        test_hist_clr();
        test_saturation();
        test_rounding();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
